// File: rtl/buzz_pkg.sv
// ============================================================================
// Module   : buzz_pkg
// Purpose  : Shared state encoding, active-id codes and default timing
//            constants for the keypad-lock buzzer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package buzz_pkg;

    // Sequencer states
    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_KEY     = 3'd1;
    localparam logic [2:0] c_S_OK      = 3'd2;
    localparam logic [2:0] c_S_ERR_ON1 = 3'd3;
    localparam logic [2:0] c_S_ERR_GAP = 3'd4;
    localparam logic [2:0] c_S_ERR_ON2 = 3'd5;

    // active_id codes; numerically ordered by priority so a plain compare arbitrates
    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_KEY  = 2'd1;
    localparam logic [1:0] ID_OK   = 2'd2;
    localparam logic [1:0] ID_ERR  = 2'd3;

    // Default timing at a 50 MHz clock
    localparam int unsigned c_DEF_KEY_HALF = 50000;
    localparam int unsigned c_DEF_KEY_DUR  = 10000000;
    localparam int unsigned c_DEF_OK_HALF  = 25000;
    localparam int unsigned c_DEF_OK_DUR   = 30000000;
    localparam int unsigned c_DEF_ERR_HALF = 100000;
    localparam int unsigned c_DEF_ERR_SEG  = 5000000;
    localparam int unsigned c_DEF_CNT_W    = 32;

endpackage

`default_nettype wire

// File: rtl/buzz_tone_gen.sv
// ============================================================================
// Module   : buzz_tone_gen
// Purpose  : Square-wave generator shared by every tone. Counts 0..half-1 and
//            toggles the output at the top of the count. restart forces the
//            wave high with a fresh phase; dropping run parks it low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buzz_tone_gen
    import buzz_pkg::*;
#(
    parameter int unsigned CNT_W = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] half_period,
    input  logic             run,
    input  logic             restart,
    output logic             wave
);

    logic [CNT_W-1:0] r_tone_cnt;
    logic             r_wave;
    logic [CNT_W-1:0] w_last;

    assign w_last = half_period - CNT_W'(1);

    // Half-period counter and toggle flop; restart has priority over run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tone_cnt <= '0;
            r_wave     <= 1'b0;
        end else if (restart) begin
            r_tone_cnt <= '0;
            r_wave     <= 1'b1;
        end else if (!run) begin
            r_tone_cnt <= '0;
            r_wave     <= 1'b0;
        end else if (r_tone_cnt == w_last) begin
            r_tone_cnt <= '0;
            r_wave     <= ~r_wave;
        end else begin
            r_tone_cnt <= r_tone_cnt + CNT_W'(1);
        end
    end

    assign wave = r_wave;

endmodule

`default_nettype wire

// File: rtl/buzzer_arbiter.sv
// ============================================================================
// Module   : buzzer_arbiter
// Purpose  : Fixed-priority arbiter (err > ok > key) and sequencer for the
//            single piezo buzzer of the keypad lock. Drives tone waveform,
//            duration and the fail-tone on/gap/on cadence.
// Options  : BUZZ_MUTE_EN - adds a mute input that forces buzzer low while
//            the sequencer keeps running.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buzzer_arbiter
    import buzz_pkg::*;
#(
    parameter int unsigned KEY_HALF = c_DEF_KEY_HALF,
    parameter int unsigned KEY_DUR  = c_DEF_KEY_DUR,
    parameter int unsigned OK_HALF  = c_DEF_OK_HALF,
    parameter int unsigned OK_DUR   = c_DEF_OK_DUR,
    parameter int unsigned ERR_HALF = c_DEF_ERR_HALF,
    parameter int unsigned ERR_SEG  = c_DEF_ERR_SEG,
    parameter int unsigned CNT_W    = c_DEF_CNT_W
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       req_key,
    input  logic       req_ok,
    input  logic       req_err,
`ifdef BUZZ_MUTE_EN
    input  logic       mute,
`endif
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_id
);

    // Terminal duration counts, folded at elaboration
    localparam logic [CNT_W-1:0] c_KEY_LAST  = CNT_W'(KEY_DUR - 1);
    localparam logic [CNT_W-1:0] c_OK_LAST   = CNT_W'(OK_DUR - 1);
    localparam logic [CNT_W-1:0] c_SEG1_LAST = CNT_W'(ERR_SEG - 1);
    localparam logic [CNT_W-1:0] c_SEG2_LAST = CNT_W'(2 * ERR_SEG - 1);
    localparam logic [CNT_W-1:0] c_SEG3_LAST = CNT_W'(3 * ERR_SEG - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [1:0]       r_active_id;
    logic [1:0]       w_id_nxt;
    logic [CNT_W-1:0] r_dur_cnt;
    logic [CNT_W-1:0] w_dur_nxt;
    logic [1:0]       w_req_id;
    logic             w_accept;
    logic             w_tone_restart;
    logic             w_tone_run;
    logic [CNT_W-1:0] w_half;
    logic             w_wave;

    // Highest-priority request of this cycle
    always_comb begin
        w_req_id = ID_NONE;
        if (req_err)      w_req_id = ID_ERR;
        else if (req_ok)  w_req_id = ID_OK;
        else if (req_key) w_req_id = ID_KEY;
    end

    // Equal priority restarts the tone; lower priority is simply dropped
    assign w_accept = (w_req_id != ID_NONE) && (w_req_id >= r_active_id);

    // Next-state, duration and tone-restart decode
    always_comb begin
        w_state_nxt    = r_state;
        w_id_nxt       = r_active_id;
        w_dur_nxt      = r_dur_cnt;
        w_tone_restart = 1'b0;
        if (w_accept) begin
            case (w_req_id)
                ID_KEY:  w_state_nxt = c_S_KEY;
                ID_OK:   w_state_nxt = c_S_OK;
                ID_ERR:  w_state_nxt = c_S_ERR_ON1;
                default: w_state_nxt = c_S_IDLE;
            endcase
            w_id_nxt       = w_req_id;
            w_dur_nxt      = '0;
            w_tone_restart = 1'b1;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    w_dur_nxt = '0;
                end
                c_S_KEY: begin
                    if (r_dur_cnt == c_KEY_LAST) begin
                        w_state_nxt = c_S_IDLE;
                        w_id_nxt    = ID_NONE;
                        w_dur_nxt   = '0;
                    end else begin
                        w_dur_nxt = r_dur_cnt + CNT_W'(1);
                    end
                end
                c_S_OK: begin
                    if (r_dur_cnt == c_OK_LAST) begin
                        w_state_nxt = c_S_IDLE;
                        w_id_nxt    = ID_NONE;
                        w_dur_nxt   = '0;
                    end else begin
                        w_dur_nxt = r_dur_cnt + CNT_W'(1);
                    end
                end
                c_S_ERR_ON1: begin
                    if (r_dur_cnt == c_SEG1_LAST) w_state_nxt = c_S_ERR_GAP;
                    w_dur_nxt = r_dur_cnt + CNT_W'(1);
                end
                c_S_ERR_GAP: begin
                    // Second burst starts high with a fresh phase
                    if (r_dur_cnt == c_SEG2_LAST) begin
                        w_state_nxt    = c_S_ERR_ON2;
                        w_tone_restart = 1'b1;
                    end
                    w_dur_nxt = r_dur_cnt + CNT_W'(1);
                end
                c_S_ERR_ON2: begin
                    if (r_dur_cnt == c_SEG3_LAST) begin
                        w_state_nxt = c_S_IDLE;
                        w_id_nxt    = ID_NONE;
                        w_dur_nxt   = '0;
                    end else begin
                        w_dur_nxt = r_dur_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                    w_id_nxt    = ID_NONE;
                    w_dur_nxt   = '0;
                end
            endcase
        end
    end

    // Tone keeps running only while the next state is an audible one
    assign w_tone_run = (w_state_nxt == c_S_KEY)     || (w_state_nxt == c_S_OK) ||
                        (w_state_nxt == c_S_ERR_ON1) || (w_state_nxt == c_S_ERR_ON2);

    // Half-period select for the shared tone generator
    always_comb begin
        case (r_state)
            c_S_KEY: w_half = CNT_W'(KEY_HALF);
            c_S_OK:  w_half = CNT_W'(OK_HALF);
            default: w_half = CNT_W'(ERR_HALF);
        endcase
    end

    // Sequencer state, duration counter and active id registers
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= c_S_IDLE;
            r_active_id <= ID_NONE;
            r_dur_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_active_id <= w_id_nxt;
            r_dur_cnt   <= w_dur_nxt;
        end
    end

    buzz_tone_gen #(
        .CNT_W (CNT_W)
    ) u_tone (
        .clk         (clk),
        .rst         (RST),
        .half_period (w_half),
        .run         (w_tone_run),
        .restart     (w_tone_restart),
        .wave        (w_wave)
    );

`ifdef BUZZ_MUTE_EN
    // Mute gates only the pin; the waveform keeps its phase underneath
    assign buzzer = w_wave & ~mute;
`else
    assign buzzer = w_wave;
`endif

    assign busy      = (r_state != c_S_IDLE);
    assign active_id = r_active_id;

endmodule

`default_nettype wire

// File: tb/tb_buzzer_arbiter.sv
// ============================================================================
// Module   : tb_buzzer_arbiter
// Purpose  : Self-checking bench for buzzer_arbiter with short timing.
//            Vector table of {inputs, expected outputs}; expectations are
//            queued when a vector is driven and compared after the edge.
// Revision : 1.1 - reset-state and end-of-run idle checks
// ============================================================================
`default_nettype none

module tb_buzzer_arbiter;

    localparam int unsigned T_KEY_HALF = 2;
    localparam int unsigned T_KEY_DUR  = 12;
    localparam int unsigned T_OK_HALF  = 1;
    localparam int unsigned T_OK_DUR   = 8;
    localparam int unsigned T_ERR_HALF = 3;
    localparam int unsigned T_ERR_SEG  = 6;

    localparam int K_KEY = 1;
    localparam int K_OK  = 2;
    localparam int K_ERR = 3;

    localparam int c_IDLE_WAIT = 64;

    typedef struct {
        logic       rst;
        logic       rk;
        logic       ro;
        logic       re;
        logic       mu;
        logic       b;
        logic       bu;
        logic [1:0] id;
    } vec_t;

    logic       clk = 1'b0;
    logic       RST;
    logic       req_key;
    logic       req_ok;
    logic       req_err;
    logic       mute;
    logic       buzzer;
    logic       busy;
    logic [1:0] active_id;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    buzzer_arbiter #(
        .KEY_HALF (T_KEY_HALF),
        .KEY_DUR  (T_KEY_DUR),
        .OK_HALF  (T_OK_HALF),
        .OK_DUR   (T_OK_DUR),
        .ERR_HALF (T_ERR_HALF),
        .ERR_SEG  (T_ERR_SEG),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .req_key   (req_key),
        .req_ok    (req_ok),
        .req_err   (req_err),
`ifdef BUZZ_MUTE_EN
        .mute      (mute),
`endif
        .buzzer    (buzzer),
        .busy      (busy),
        .active_id (active_id)
    );

    // Audible length of a tone in cycles
    function automatic int tone_len(input int kind);
        if (kind == K_KEY) return int'(T_KEY_DUR);
        if (kind == K_OK)  return int'(T_OK_DUR);
        return int'(3 * T_ERR_SEG);
    endfunction

    // Expected buzzer level in tone cycle c (cycle 1 is the first after the request)
    function automatic logic exp_wave(input int kind, input int c);
        int h;
        int s;
        s = int'(T_ERR_SEG);
        if (kind == K_KEY) begin
            h = int'(T_KEY_HALF);
            return (c >= 1 && c <= int'(T_KEY_DUR)) && (((c - 1) / h) % 2 == 0);
        end
        if (kind == K_OK) begin
            h = int'(T_OK_HALF);
            return (c >= 1 && c <= int'(T_OK_DUR)) && (((c - 1) / h) % 2 == 0);
        end
        h = int'(T_ERR_HALF);
        if (c >= 1 && c <= s)             return ((c - 1) / h) % 2 == 0;
        if (c >= 2 * s + 1 && c <= 3 * s) return ((c - 2 * s - 1) / h) % 2 == 0;
        return 1'b0;
    endfunction

    task automatic add_row(input logic rst, input logic [2:0] rq, input logic mu,
                           input logic b, input logic bu, input logic [1:0] id);
        vec_t v;
        v.rst = rst; v.rk = rq[0]; v.ro = rq[1]; v.re = rq[2]; v.mu = mu;
        v.b = b; v.bu = bu; v.id = id;
        vecs.push_back(v);
    endtask

    // Rows of one tone: row 0 carries first_req, optional extra request at inj_row
    task automatic add_tone(input int kind, input int n_rows, input logic mu,
                            input logic [2:0] first_req, input int inj_row,
                            input logic [2:0] inj_req);
        for (int r = 0; r < n_rows; r++) begin
            logic [2:0] rq;
            int         c;
            rq = (r == 0) ? first_req : ((r == inj_row) ? inj_req : 3'b000);
            c  = r + 1;
            if (c <= tone_len(kind))
                add_row(1'b0, rq, mu, exp_wave(kind, c) & ~mu, 1'b1, 2'(kind));
            else
                add_row(1'b0, rq, mu, 1'b0, 1'b0, 2'd0);
        end
    endtask

    task automatic build();
        // Reset state; a request during reset is dropped
        add_row(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
        add_row(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0);
        add_row(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
        // Key click, full length
        add_tone(K_KEY, 13, 1'b0, 3'b001, -1, 3'b000);
        // Fail tone, with an ok request in the gap that must be dropped
        add_tone(K_ERR, 19, 1'b0, 3'b100, 8, 3'b010);
        // All three at once: err wins, key in second burst dropped
        add_tone(K_ERR, 19, 1'b0, 3'b111, 14, 3'b001);
        // Pass tone with a key request at dur_cnt=3 that must be ignored
        add_tone(K_OK, 9, 1'b0, 3'b010, 4, 3'b001);
        // Pass tone preempted by fail at dur_cnt=3
        add_tone(K_OK, 4, 1'b0, 3'b010, -1, 3'b000);
        add_tone(K_ERR, 19, 1'b0, 3'b100, -1, 3'b000);
        // Key restarted by a second key request
        add_tone(K_KEY, 5, 1'b0, 3'b001, -1, 3'b000);
        add_tone(K_KEY, 13, 1'b0, 3'b001, -1, 3'b000);
        // Reset during ERR_GAP, then a normal pass tone
        add_tone(K_ERR, 9, 1'b0, 3'b100, -1, 3'b000);
        add_row(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0);
        add_tone(K_OK, 9, 1'b0, 3'b010, -1, 3'b000);
`ifdef BUZZ_MUTE_EN
        // Muted key click: silent pin, sequencer unchanged
        add_tone(K_KEY, 13, 1'b1, 3'b001, -1, 3'b000);
`endif
    endtask

    initial begin
        vec_t e;
        int   w;
        RST     = 1'b1;
        req_key = 1'b0;
        req_ok  = 1'b0;
        req_err = 1'b0;
        mute    = 1'b0;
        build();

        // Reset-state check after the first reset edge
        @(posedge clk);
        #1;
        if (buzzer !== 1'b0 || busy !== 1'b0 || active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset state buzzer/busy/active_id: got %b/%b/%0d required 0/0/0",
                     buzzer, busy, active_id);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            RST     = vecs[i].rst;
            req_key = vecs[i].rk;
            req_ok  = vecs[i].ro;
            req_err = vecs[i].re;
            mute    = vecs[i].mu;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if (buzzer !== e.b || busy !== e.bu || active_id !== e.id) begin
                n_fail++;
                $display("FAIL vec%0d buzzer/busy/active_id: got %b/%b/%0d required %b/%b/%0d",
                         i, buzzer, busy, active_id, e.b, e.bu, e.id);
            end
        end

        // Bounded wait for the sequencer to return to idle
        @(negedge clk);
        RST     = 1'b0;
        req_key = 1'b0;
        req_ok  = 1'b0;
        req_err = 1'b0;
        mute    = 1'b0;
        w = 0;
        while (busy === 1'b1 && w < c_IDLE_WAIT) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle wait expired after %0d cycles: busy=%b active_id=%0d",
                     w, busy, active_id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
